register_bank_param: RTL and testbench
======================================

// Module: register_bank_param
// PURPOSE
//  Parametrised general-purpose/scratch register bank for the datapath: NUM_REGS registers of DATA_W bits.
//  Each register has its own enable and applies a shared FunSel operation on the clock edge.
//  Two independent registered read ports (A, B) with write-forwarding, plus per-port zero flags.
//  Sits between the ALU result bus (i) and the ALU operand inputs (OutA, OutB).
// PARAMETERS
//  DATA_W    32  register and bus width in bits (>= 4, even)
//  NUM_REGS  8   number of registers (2..16); index 0 is the first register
//  SEL_W     3   read-select width, = $clog2(NUM_REGS); caller must keep them consistent
// PORTS
//  clock    in   1         single clock; all state updates on posedge
//  reset    in   1         synchronous, active-high
//  i        in   DATA_W    write data
//  RegEn    in   NUM_REGS  per-register enable; bit k enables register k; any number may be set
//  FunSel   in   3         operation applied to every enabled register
//  OutASel  in   SEL_W     read-port A register index
//  OutBSel  in   SEL_W     read-port B register index
//  OutA     out  DATA_W    registered read data, port A
//  OutB     out  DATA_W    registered read data, port B
//  ZeroA    out  1         registered; 1 when OutA == 0
//  ZeroB    out  1         registered; 1 when OutB == 0
// BEHAVIOUR
//  Reset: when reset=1 at a posedge, all registers, OutA, OutB <= 0; ZeroA, ZeroB <= 1.
//   Reset overrides RegEn/FunSel in that cycle.
//  Register update, per register k at posedge with RegEn[k]=1 (H = DATA_W/2):
//   000 DEC   R <= R - 1, modulo 2^DATA_W (0 -> all ones)
//   001 INC   R <= R + 1, modulo 2^DATA_W (all ones -> 0)
//   010 LOAD  R <= i
//   011 CLR   R <= 0
//   100 LDLZ  R <= {H zeros, i[H-1:0]}
//   101 LDLK  R <= {R[DATA_W-1:H], i[H-1:0]}
//   110 SHL   R <= {R[DATA_W-2:0], 1'b0}
//   111 ASR   R <= {R[DATA_W-1], R[DATA_W-1:1]}
//  RegEn[k]=0: register k holds. RegEn all zero: bank holds; read ports still update.
//  Read ports are registered, 1-cycle latency.
//   OutX at edge N+1 reflects the sel sampled at edge N and the register value after edge N's update
//   (write-forwarding: reading a register written in the same cycle returns the new value, never stale).
//   Zero flag is computed from the same forwarded value and updates on the same edge as OutX.
//  A and B may select the same register; both return identical data.
//  Sel >= NUM_REGS (non-power-of-2 depth): OutX <= 0, ZeroX <= 1; no error state.
//  No multi-cycle state: reset mid-stream cleanly discards the in-flight operation.
//  No combinational path from any input to any output.
// TESTING
//  1 reset=1 one cycle after random loads -> every register reads 0 on both ports; ZeroA=ZeroB=1.
//  2 RegEn=8'h01, FunSel=010, i=32'hDEADBEEF, OutASel=0 same cycle -> next cycle OutA=32'hDEADBEEF (forwarded), ZeroA=0.
//  3 R1=32'hFFFFFFFF, INC -> 0, ZeroA=1; then DEC -> 32'hFFFFFFFF.
//  4 R2=32'h12345678, LDLK, i=32'h0000ABCD -> 32'h1234ABCD; then LDLZ, i=32'hFFFF0001 -> 32'h00000001.
//  5 R3=32'h80000002: ASR -> 32'hC0000001; SHL -> 32'h80000002; RegEn=8'hFF, CLR -> all regs 0.
//  6 NUM_REGS=6, SEL_W=3, OutBSel=7 -> OutB=0, ZeroB=1; OutASel=OutBSel=5 -> identical outputs.

Source files
------------

// File: rtl/register_bank_param.sv
// register_bank_param
//   Parametrised scratch register bank between the ALU result bus and the
//   ALU operand inputs. NUM_REGS registers of DATA_W bits. Each enabled
//   register applies the shared FunSel operation on the clock edge. There are
//   two registered read ports with write-forwarding and per-port zero flags.
//
// Ports
//   clock    in   1         all state updates on posedge
//   reset    in   1         synchronous, active-high; clears bank and read ports
//   i        in   DATA_W    write data
//   RegEn    in   NUM_REGS  per-register enable (bit k -> register k)
//   FunSel   in   3         operation applied to every enabled register
//   OutASel  in   SEL_W     read-port A register index
//   OutBSel  in   SEL_W     read-port B register index
//   OutA     out  DATA_W    registered read data, port A
//   OutB     out  DATA_W    registered read data, port B
//   ZeroA    out  1         registered, high when OutA == 0
//   ZeroB    out  1         registered, high when OutB == 0
module register_bank_param #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned SEL_W    = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [DATA_W-1:0]   i,
    input  logic [NUM_REGS-1:0] RegEn,
    input  logic [2:0]          FunSel,
    input  logic [SEL_W-1:0]    OutASel,
    input  logic [SEL_W-1:0]    OutBSel,
    output logic [DATA_W-1:0]   OutA,
    output logic [DATA_W-1:0]   OutB,
    output logic                ZeroA,
    output logic                ZeroB
);

    localparam int unsigned H = DATA_W / 2;

    localparam logic [2:0] OP_DEC  = 3'b000;
    localparam logic [2:0] OP_INC  = 3'b001;
    localparam logic [2:0] OP_LOAD = 3'b010;
    localparam logic [2:0] OP_CLR  = 3'b011;
    localparam logic [2:0] OP_LDLZ = 3'b100;
    localparam logic [2:0] OP_LDLK = 3'b101;
    localparam logic [2:0] OP_SHL  = 3'b110;

    logic [DATA_W-1:0] regs     [NUM_REGS];
    logic [DATA_W-1:0] regs_nxt [NUM_REGS];
    logic [DATA_W-1:0] rd_a_c;
    logic [DATA_W-1:0] rd_b_c;

    // Next value of every register after this edge's operation.
    always_comb begin
        for (int k = 0; k < NUM_REGS; k++) begin
            regs_nxt[k] = regs[k];
            if (RegEn[k]) begin
                case (FunSel)
                    OP_DEC:  regs_nxt[k] = regs[k] - DATA_W'(1);
                    OP_INC:  regs_nxt[k] = regs[k] + DATA_W'(1);
                    OP_LOAD: regs_nxt[k] = i;
                    OP_CLR:  regs_nxt[k] = '0;
                    OP_LDLZ: regs_nxt[k] = {{H{1'b0}}, i[H-1:0]};
                    OP_LDLK: regs_nxt[k] = {regs[k][DATA_W-1:H], i[H-1:0]};
                    OP_SHL:  regs_nxt[k] = {regs[k][DATA_W-2:0], 1'b0};
                    default: regs_nxt[k] = {regs[k][DATA_W-1], regs[k][DATA_W-1:1]};
                endcase
            end
        end
    end

    // Read muxes select from the post-update values so a same-cycle write is
    // forwarded; a select with no matching register falls through to zero.
    always_comb begin
        rd_a_c = '0;
        rd_b_c = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (OutASel == SEL_W'(k)) rd_a_c = regs_nxt[k];
            if (OutBSel == SEL_W'(k)) rd_b_c = regs_nxt[k];
        end
    end

    // Bank state and registered read ports.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
            OutA  <= '0;
            OutB  <= '0;
            ZeroA <= 1'b1;
            ZeroB <= 1'b1;
        end else begin
            for (int k = 0; k < NUM_REGS; k++) regs[k] <= regs_nxt[k];
            OutA  <= rd_a_c;
            OutB  <= rd_b_c;
            ZeroA <= (rd_a_c == '0);
            ZeroB <= (rd_b_c == '0);
        end
    end

endmodule

// File: tb/tb_register_bank_param.sv
// tb_register_bank_param
//   Scoreboard bench for register_bank_param. Two instances share stimulus:
//   an 8-register bank and a 6-register bank (non-power-of-2 depth).
//   Each row of stimulus pushes its expected read-port result when driven;
//   the result is popped and compared one edge later.
module tb_register_bank_param;

    logic        clock;
    logic        reset;
    logic [31:0] i;
    logic [7:0]  RegEn;
    logic [2:0]  FunSel;
    logic [2:0]  OutASel;
    logic [2:0]  OutBSel;
    logic [31:0] OutA8, OutB8, OutA6, OutB6;
    logic        ZeroA8, ZeroB8, ZeroA6, ZeroB6;

    int passed = 0;
    int total  = 0;

    typedef struct {
        bit          rst;
        logic [7:0]  en;
        logic [2:0]  fs;
        logic [31:0] d;
        logic [2:0]  asel;
        logic [2:0]  bsel;
        logic [31:0] ea;
        logic [31:0] eb;
        bit          ck;
        bit          on6;
        string       nm;
    } stim_t;

    stim_t       stim_q[$];
    stim_t       exp_q[$];
    logic [31:0] mdl [8];

    register_bank_param #(.DATA_W(32), .NUM_REGS(8), .SEL_W(3)) u8 (
        .clock(clock), .reset(reset), .i(i), .RegEn(RegEn), .FunSel(FunSel),
        .OutASel(OutASel), .OutBSel(OutBSel),
        .OutA(OutA8), .OutB(OutB8), .ZeroA(ZeroA8), .ZeroB(ZeroB8)
    );

    register_bank_param #(.DATA_W(32), .NUM_REGS(6), .SEL_W(3)) u6 (
        .clock(clock), .reset(reset), .i(i), .RegEn(RegEn[5:0]), .FunSel(FunSel),
        .OutASel(OutASel), .OutBSel(OutBSel),
        .OutA(OutA6), .OutB(OutB6), .ZeroA(ZeroA6), .ZeroB(ZeroB6)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic void row(bit rst, logic [7:0] en, logic [2:0] fs, logic [31:0] d,
                                logic [2:0] asel, logic [2:0] bsel,
                                logic [31:0] ea, logic [31:0] eb, bit ck, bit on6, string nm);
        stim_t s;
        s.rst = rst; s.en = en; s.fs = fs; s.d = d; s.asel = asel; s.bsel = bsel;
        s.ea = ea; s.eb = eb; s.ck = ck; s.on6 = on6; s.nm = nm;
        stim_q.push_back(s);
    endfunction

    // Reference behaviour of one enabled register.
    function automatic logic [31:0] apply_op(logic [2:0] fs, logic [31:0] r, logic [31:0] d);
        case (fs)
            3'd0:    return r - 32'd1;
            3'd1:    return r + 32'd1;
            3'd2:    return d;
            3'd3:    return 32'd0;
            3'd4:    return d & 32'h0000FFFF;
            3'd5:    return (r & 32'hFFFF0000) | (d & 32'h0000FFFF);
            3'd6:    return r << 1;
            default: return 32'($signed(r) >>> 1);
        endcase
    endfunction

    // Drive one row and record what the read ports should show after the edge.
    task automatic apply_row(input stim_t s);
        reset   = s.rst;
        RegEn   = s.en;
        FunSel  = s.fs;
        i       = s.d;
        OutASel = s.asel;
        OutBSel = s.bsel;
        exp_q.push_back(s);
    endtask

    task automatic test_reset();
        stim_t s, e;
        logic [31:0] ga, gb, v;
        logic za, zb;
        row(1, 8'h00, 3'd0, 32'h0, 3'd0, 3'd7, 32'h0, 32'h0, 1, 0, "reset_initial");
        for (int k = 0; k < 4; k++) begin
            v = $urandom() | 32'h1;
            row(0, 8'hFF, 3'd2, v, 3'(k), 3'(k + 4), v, v, 1, 0, "random_load");
        end
        row(1, 8'hFF, 3'd2, 32'h12345678, 3'd3, 3'd3, 32'h0, 32'h0, 1, 0, "reset_overrides_load");
        for (int k = 0; k < 8; k++)
            row(0, 8'h00, 3'd1, 32'hFFFFFFFF, 3'(k), 3'(7 - k), 32'h0, 32'h0, 1, 0, "read_after_reset");
        while (stim_q.size() != 0) begin
            s = stim_q.pop_front();
            apply_row(s);
            @(posedge clock); #1;
            e  = exp_q.pop_front();
            ga = e.on6 ? OutA6 : OutA8;  za = e.on6 ? ZeroA6 : ZeroA8;
            gb = e.on6 ? OutB6 : OutB8;  zb = e.on6 ? ZeroB6 : ZeroB8;
            if (e.ck) begin
                total++;
                if (ga !== e.ea || za !== (e.ea == 32'h0))
                    $display("FAIL %s A: got %h/%b want %h/%b", e.nm, ga, za, e.ea, e.ea == 32'h0);
                else passed++;
                total++;
                if (gb !== e.eb || zb !== (e.eb == 32'h0))
                    $display("FAIL %s B: got %h/%b want %h/%b", e.nm, gb, zb, e.eb, e.eb == 32'h0);
                else passed++;
            end
        end
    endtask

    task automatic test_forward();
        stim_t s, e;
        logic [31:0] ga, gb;
        logic za, zb;
        row(0, 8'h01, 3'd2, 32'hDEADBEEF, 3'd0, 3'd0, 32'hDEADBEEF, 32'hDEADBEEF, 1, 0, "forward_load_r0");
        row(0, 8'h00, 3'd2, 32'h11111111, 3'd1, 3'd0, 32'h0, 32'hDEADBEEF, 1, 0, "hold_when_disabled");
        while (stim_q.size() != 0) begin
            s = stim_q.pop_front();
            apply_row(s);
            @(posedge clock); #1;
            e  = exp_q.pop_front();
            ga = e.on6 ? OutA6 : OutA8;  za = e.on6 ? ZeroA6 : ZeroA8;
            gb = e.on6 ? OutB6 : OutB8;  zb = e.on6 ? ZeroB6 : ZeroB8;
            if (e.ck) begin
                total++;
                if (ga !== e.ea || za !== (e.ea == 32'h0))
                    $display("FAIL %s A: got %h/%b want %h/%b", e.nm, ga, za, e.ea, e.ea == 32'h0);
                else passed++;
                total++;
                if (gb !== e.eb || zb !== (e.eb == 32'h0))
                    $display("FAIL %s B: got %h/%b want %h/%b", e.nm, gb, zb, e.eb, e.eb == 32'h0);
                else passed++;
            end
        end
    endtask

    task automatic test_arith();
        stim_t s, e;
        logic [31:0] ga, gb;
        logic za, zb;
        row(0, 8'h02, 3'd2, 32'hFFFFFFFF, 3'd1, 3'd0, 32'hFFFFFFFF, 32'hDEADBEEF, 1, 0, "load_r1_ones");
        row(0, 8'h02, 3'd1, 32'h0, 3'd1, 3'd1, 32'h0, 32'h0, 1, 0, "inc_wraps_to_zero");
        row(0, 8'h02, 3'd0, 32'h0, 3'd1, 3'd0, 32'hFFFFFFFF, 32'hDEADBEEF, 1, 0, "dec_wraps_to_ones");
        while (stim_q.size() != 0) begin
            s = stim_q.pop_front();
            apply_row(s);
            @(posedge clock); #1;
            e  = exp_q.pop_front();
            ga = e.on6 ? OutA6 : OutA8;  za = e.on6 ? ZeroA6 : ZeroA8;
            gb = e.on6 ? OutB6 : OutB8;  zb = e.on6 ? ZeroB6 : ZeroB8;
            if (e.ck) begin
                total++;
                if (ga !== e.ea || za !== (e.ea == 32'h0))
                    $display("FAIL %s A: got %h/%b want %h/%b", e.nm, ga, za, e.ea, e.ea == 32'h0);
                else passed++;
                total++;
                if (gb !== e.eb || zb !== (e.eb == 32'h0))
                    $display("FAIL %s B: got %h/%b want %h/%b", e.nm, gb, zb, e.eb, e.eb == 32'h0);
                else passed++;
            end
        end
    endtask

    task automatic test_load_shift();
        stim_t s, e;
        logic [31:0] ga, gb;
        logic za, zb;
        row(0, 8'h04, 3'd2, 32'h12345678, 3'd2, 3'd1, 32'h12345678, 32'hFFFFFFFF, 1, 0, "load_r2");
        row(0, 8'h04, 3'd5, 32'h0000ABCD, 3'd2, 3'd2, 32'h1234ABCD, 32'h1234ABCD, 1, 0, "ldlk_keeps_high");
        row(0, 8'h04, 3'd4, 32'hFFFF0001, 3'd2, 3'd2, 32'h00000001, 32'h00000001, 1, 0, "ldlz_zeroes_high");
        row(0, 8'h08, 3'd2, 32'h80000002, 3'd3, 3'd2, 32'h80000002, 32'h00000001, 1, 0, "load_r3");
        row(0, 8'h08, 3'd7, 32'h0, 3'd3, 3'd3, 32'hC0000001, 32'hC0000001, 1, 0, "asr_sign_extends");
        row(0, 8'h08, 3'd6, 32'h0, 3'd3, 3'd0, 32'h80000002, 32'hDEADBEEF, 1, 0, "shl_drops_msb");
        row(0, 8'hFF, 3'd3, 32'hFFFFFFFF, 3'd0, 3'd7, 32'h0, 32'h0, 1, 0, "clr_all");
        for (int k = 1; k < 7; k++)
            row(0, 8'h00, 3'd2, 32'h5, 3'(k), 3'(k), 32'h0, 32'h0, 1, 0, "read_after_clr");
        while (stim_q.size() != 0) begin
            s = stim_q.pop_front();
            apply_row(s);
            @(posedge clock); #1;
            e  = exp_q.pop_front();
            ga = e.on6 ? OutA6 : OutA8;  za = e.on6 ? ZeroA6 : ZeroA8;
            gb = e.on6 ? OutB6 : OutB8;  zb = e.on6 ? ZeroB6 : ZeroB8;
            if (e.ck) begin
                total++;
                if (ga !== e.ea || za !== (e.ea == 32'h0))
                    $display("FAIL %s A: got %h/%b want %h/%b", e.nm, ga, za, e.ea, e.ea == 32'h0);
                else passed++;
                total++;
                if (gb !== e.eb || zb !== (e.eb == 32'h0))
                    $display("FAIL %s B: got %h/%b want %h/%b", e.nm, gb, zb, e.eb, e.eb == 32'h0);
                else passed++;
            end
        end
    endtask

    // Six-register instance: selects 6 and 7 have no register behind them.
    task automatic test_nonpow2();
        stim_t s, e;
        logic [31:0] ga, gb;
        logic za, zb;
        row(0, 8'h20, 3'd2, 32'h5A5A0001, 3'd5, 3'd7, 32'h5A5A0001, 32'h0, 1, 1, "n6_load_r5_sel7");
        row(0, 8'h00, 3'd2, 32'hFFFFFFFF, 3'd5, 3'd5, 32'h5A5A0001, 32'h5A5A0001, 1, 1, "n6_same_sel");
        row(0, 8'h00, 3'd2, 32'hFFFFFFFF, 3'd6, 3'd5, 32'h0, 32'h5A5A0001, 1, 1, "n6_sel6");
        row(0, 8'h20, 3'd1, 32'h0, 3'd7, 3'd5, 32'h0, 32'h5A5A0002, 1, 1, "n6_sel7_inc");
        while (stim_q.size() != 0) begin
            s = stim_q.pop_front();
            apply_row(s);
            @(posedge clock); #1;
            e  = exp_q.pop_front();
            ga = e.on6 ? OutA6 : OutA8;  za = e.on6 ? ZeroA6 : ZeroA8;
            gb = e.on6 ? OutB6 : OutB8;  zb = e.on6 ? ZeroB6 : ZeroB8;
            if (e.ck) begin
                total++;
                if (ga !== e.ea || za !== (e.ea == 32'h0))
                    $display("FAIL %s A: got %h/%b want %h/%b", e.nm, ga, za, e.ea, e.ea == 32'h0);
                else passed++;
                total++;
                if (gb !== e.eb || zb !== (e.eb == 32'h0))
                    $display("FAIL %s B: got %h/%b want %h/%b", e.nm, gb, zb, e.eb, e.eb == 32'h0);
                else passed++;
            end
        end
    endtask

    // Random back-to-back operations on the 8-register bank against the model.
    task automatic test_back_to_back();
        stim_t s, e;
        logic [31:0] ga, gb, d;
        logic [7:0]  en;
        logic [2:0]  fs, as, bs;
        logic za, zb;
        for (int k = 0; k < 8; k++) mdl[k] = 32'h0;
        row(1, 8'h00, 3'd0, 32'h0, 3'd0, 3'd1, 32'h0, 32'h0, 1, 0, "b2b_reset");
        for (int n = 0; n < 60; n++) begin
            en = 8'($urandom());
            fs = 3'($urandom_range(0, 7));
            d  = (n % 7 == 0) ? 32'h0 : $urandom();
            as = 3'($urandom_range(0, 7));
            bs = 3'($urandom_range(0, 7));
            for (int k = 0; k < 8; k++)
                if (en[k]) mdl[k] = apply_op(fs, mdl[k], d);
            row(0, en, fs, d, as, bs, mdl[as], mdl[bs], 1, 0, "b2b_random");
        end
        while (stim_q.size() != 0) begin
            s = stim_q.pop_front();
            apply_row(s);
            @(posedge clock); #1;
            e  = exp_q.pop_front();
            ga = e.on6 ? OutA6 : OutA8;  za = e.on6 ? ZeroA6 : ZeroA8;
            gb = e.on6 ? OutB6 : OutB8;  zb = e.on6 ? ZeroB6 : ZeroB8;
            if (e.ck) begin
                total++;
                if (ga !== e.ea || za !== (e.ea == 32'h0))
                    $display("FAIL %s A: got %h/%b want %h/%b", e.nm, ga, za, e.ea, e.ea == 32'h0);
                else passed++;
                total++;
                if (gb !== e.eb || zb !== (e.eb == 32'h0))
                    $display("FAIL %s B: got %h/%b want %h/%b", e.nm, gb, zb, e.eb, e.eb == 32'h0);
                else passed++;
            end
        end
    endtask

    initial begin
        reset   = 1'b1;
        i       = 32'h0;
        RegEn   = 8'h00;
        FunSel  = 3'd0;
        OutASel = 3'd0;
        OutBSel = 3'd0;
        @(posedge clock); #1;
        test_reset();
        test_forward();
        test_arith();
        test_load_shift();
        test_nonpow2();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
